satd_block_sequencer: RTL and testbench

Sequences the shared 4x4 Hadamard/SATD datapath for one block at a time.
- Accepts a block request through a valid/ready handshake.
- Drives the datapath through a row-transform pass, then a column-transform-plus-accumulate pass, then a finish cycle.
- Reports stage/count, completion and a running block counter.
- Sits between the block fetch logic and the transform/accumulator datapath.

---
 rtl/satd_block_sequencer.sv | 129 ++++++++++++
 tb/tb_satd_block_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/satd_block_sequencer.sv
// Block sequencer for the shared 4x4 Hadamard/SATD datapath: row pass, column+accumulate pass, finish.
// Moore machine; every output is a flop loaded from the decode of the next state.
module satd_block_sequencer #(
  parameter int unsigned N         = 4,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 abort,
  output logic [1:0]           stage,
  output logic [CNT_W-1:0]     count,
  output logic                 row_en,
  output logic                 col_en,
  output logic                 acc_en,
  output logic                 acc_clr,
  output logic                 done,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_FIN  = 2'd3
  } stage_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  stage_e               stage_q, stage_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;
  logic                 start_ready_q, start_ready_d;
  logic                 row_en_q, row_en_d;
  logic                 col_en_q, col_en_d;
  logic                 acc_clr_q, acc_clr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Next state, next count and the Moore decode of the next state.
  always_comb begin
    stage_d     = stage_q;
    count_d     = count_q;
    blk_count_d = blk_count_q;

    case (stage_q)
      ST_IDLE: begin
        count_d = CNT_ZERO;
        if (start_valid) begin
          stage_d = ST_ROW;
        end
      end
      ST_ROW: begin
        if (abort) begin
          stage_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (count_q == CNT_LAST) begin
          stage_d = ST_COL;
          count_d = CNT_ZERO;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_COL: begin
        if (abort) begin
          stage_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (count_q == CNT_LAST) begin
          stage_d = ST_FIN;
          count_d = CNT_ZERO;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        stage_d     = ST_IDLE;
        count_d     = CNT_ZERO;
        blk_count_d = blk_count_q + BLK_CNT_W'(1);
      end
    endcase

    start_ready_d = (stage_d == ST_IDLE);
    row_en_d      = (stage_d == ST_ROW);
    acc_clr_d     = (stage_d == ST_ROW) && (count_d == CNT_ZERO);
    col_en_d      = (stage_d == ST_COL);
    done_d        = (stage_d == ST_FIN);
    busy_d        = (stage_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q       <= ST_IDLE;
      count_q       <= CNT_ZERO;
      blk_count_q   <= '0;
      start_ready_q <= 1'b1;
      row_en_q      <= 1'b0;
      col_en_q      <= 1'b0;
      acc_clr_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      count_q       <= count_d;
      blk_count_q   <= blk_count_d;
      start_ready_q <= start_ready_d;
      row_en_q      <= row_en_d;
      col_en_q      <= col_en_d;
      acc_clr_q     <= acc_clr_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign stage       = stage_q;
  assign count       = count_q;
  assign blk_count   = blk_count_q;
  assign start_ready = start_ready_q;
  assign row_en      = row_en_q;
  assign col_en      = col_en_q;
  assign acc_en      = col_en_q;
  assign acc_clr     = acc_clr_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_satd_block_sequencer.sv
// Bench for satd_block_sequencer: a cycle-offset model checked every cycle plus directed literal checks.
module tb_satd_block_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned BW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic          abort;
  logic [1:0]    stage;
  logic [CW-1:0] count;
  logic          row_en, col_en, acc_en, acc_clr, done, busy;
  logic [BW-1:0] blk_count;

  int checks   = 0;
  int failures = 0;

  satd_block_sequencer #(.N(N), .CNT_W(CW), .BLK_CNT_W(BW)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .stage(stage), .count(count), .row_en(row_en), .col_en(col_en),
    .acc_en(acc_en), .acc_clr(acc_clr), .done(done), .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a block is just "k cycles since acceptance"; k=1..N row, N+1..2N column, 2N+1 finish.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_blk    = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_blk    <= 0;
    end else if (!m_active) begin
      if (start_valid) begin
        m_active <= 1'b1;
        m_k      <= 1;
      end
    end else if (m_k <= 2 * N && abort) begin
      m_active <= 1'b0;
    end else if (m_k == 2 * N + 1) begin
      m_active <= 1'b0;
      m_blk    <= (m_blk + 1) % (1 << BW);
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic [31:0] pack_out(input logic [1:0] st, input logic [CW-1:0] cn,
      input logic re, input logic ce, input logic ae, input logic cl, input logic dn,
      input logic bz, input logic rd, input logic [BW-1:0] bc);
    return 32'({st, cn, re, ce, ae, cl, dn, bz, rd, bc});
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      int es, ec;
      es = !m_active ? 0 : (m_k <= N) ? 1 : (m_k <= 2 * N) ? 2 : 3;
      ec = (es == 1) ? m_k - 1 : (es == 2) ? m_k - N - 1 : 0;
      chk("model", pack_out(stage, count, row_en, col_en, acc_en, acc_clr, done, busy,
                            start_ready, blk_count),
          pack_out(2'(es), CW'(ec), es == 1, es == 2, es == 2, es == 1 && ec == 0,
                   es == 3, es != 0, es == 0, BW'(m_blk)));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  // Pulse start for one accepting edge; returns positioned in cycle 1 of the block.
  task automatic kick();
    start_valid = 1'b1;
    step(1);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      step(1);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    logic [4:0] ctl_tbl [1:10];
    int         cnt_tbl [1:10];
    int         dcyc [$];
    int         ndone;

    ctl_tbl = '{5'b10100, 5'b10000, 5'b10000, 5'b10000, 5'b01000,
                5'b01000, 5'b01000, 5'b01000, 5'b00010, 5'b00001};
    cnt_tbl = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};

    reset = 1'b0; start_valid = 1'b0; abort = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    step(2);
    chk("reset_state", pack_out(stage, count, row_en, col_en, acc_en, acc_clr, done, busy,
                                start_ready, blk_count), 32'h0000_0004);
    reset = 1'b1;
    step(1);

    // Single block: hand table of {row_en,col_en,acc_clr,done,start_ready} and count.
    kick();
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("single_ctl_c%0d", c), 32'({row_en, col_en, acc_clr, done, start_ready}),
          32'(ctl_tbl[c]));
      chk($sformatf("single_cnt_c%0d", c), 32'(count), 32'(cnt_tbl[c]));
      if (c == 10) chk("single_blk", 32'(blk_count), 32'd1);
      step(1);
    end

    // Back-to-back, three blocks with start_valid held.
    do_reset();
    start_valid = 1'b1;
    dcyc.delete();
    for (int c = 1; c <= 30; c++) begin
      step(1);
      if (done) dcyc.push_back(c);
      if (c == 10 || c == 20) chk($sformatf("b2b_idle_c%0d", c), 32'(stage), 32'd0);
    end
    start_valid = 1'b0;
    chk("b2b_ndone", 32'(dcyc.size()), 32'd3);
    if (dcyc.size() == 3) begin
      chk("b2b_done0", 32'(dcyc[0]), 32'd9);
      chk("b2b_done1", 32'(dcyc[1]), 32'd19);
      chk("b2b_done2", 32'(dcyc[2]), 32'd29);
    end
    step(1);
    chk("b2b_blk", 32'(blk_count), 32'd3);

    // Abort in COL at count 2 (cycle 7).
    do_reset();
    kick();
    step(6);
    chk("abort_pre", 32'({stage, count}), 32'({2'd2, 2'd2}));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_idle", 32'({stage, count, done, blk_count}), 32'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    kick();
    wait_done("abort_next_done");
    step(1);
    chk("abort_next_blk", 32'(blk_count), 32'd1);

    // Abort on last row count, abort in FIN ignored, abort+start in IDLE accepted.
    kick();
    step(3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_lastrow", 32'(stage), 32'd0);
    kick();
    step(8);
    abort = 1'b1;
    chk("fin_stage", 32'(stage), 32'd3);
    step(1);
    chk("fin_abort_blk", 32'(blk_count), 32'd2);
    start_valid = 1'b1;
    step(1);
    start_valid = 1'b0; abort = 1'b0;
    chk("abort_start_accept", 32'({stage, acc_clr}), 32'({2'd1, 1'b1}));
    wait_done("abort_start_done");
    step(1);

    // Reset mid-ROW at count 1; start_valid during reset must not be accepted.
    kick();
    step(1);
    chk("rst_mid_pre", 32'(count), 32'd1);
    reset = 1'b0; start_valid = 1'b1;
    step(1);
    chk("rst_mid", pack_out(stage, count, row_en, col_en, acc_en, acc_clr, done, busy,
                            start_ready, blk_count), 32'h0000_0004);
    step(1);
    reset = 1'b1; start_valid = 1'b0;
    step(1);
    chk("rst_mid_after", 32'({stage, blk_count}), 32'h0);

    // Wrap of a 2-bit block counter over five blocks.
    for (int b = 1; b <= 5; b++) begin
      kick();
      wait_done($sformatf("wrap_done%0d", b));
      step(1);
      chk($sformatf("wrap_blk%0d", b), 32'(blk_count), 32'(b % 4));
    end

    // start_valid pulsed during COL is dropped.
    do_reset();
    kick();
    step(5);
    start_valid = 1'b1;
    step(1);
    start_valid = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      chk($sformatf("busy_rdy_c%0d", c), 32'(start_ready), 32'(c == 10));
      step(1);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      step(1);
    end
    chk("busy_no_second", 32'(ndone), 32'd0);
    chk("busy_blk", 32'(blk_count), 32'd1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
